// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI bus arbiter: FSM state encoding and owner codes.
// Imported by spi_bus_arbiter and spi_arb_port_mux.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    OWN    = 2'd0,
    DRAIN  = 2'd1,
    GUARD  = 2'd2,
    SWITCH = 2'd3
  } arb_state_e;

  localparam logic OWNER_ADC = 1'b1;
  localparam logic OWNER_CAN = 1'b0;

endpackage

// File: rtl/spi_arb_port_mux.sv
// Combinational pin mux: routes the owner's SCLK/MOSI/SS to the pins, holds
// the non-owner's selects high, and parks every pin during SWITCH.
// Ports: owner_i/switch_i from the FSM; a_*/b_* master side; spi_* pin side.
module spi_arb_port_mux
  import spi_arb_pkg::*;
#(
  parameter int   SSA       = 2,
  parameter int   SSB       = 3,
  parameter logic IDLE_SCLK = 1'b0
) (
  input  logic           owner_i,
  input  logic           switch_i,
  input  logic           a_sclk_i,
  input  logic           a_mosi_i,
  input  logic [SSA-1:0] a_ss_n_i,
  input  logic           b_sclk_i,
  input  logic           b_mosi_i,
  input  logic [SSB-1:0] b_ss_n_i,
  input  logic           spi_miso_i,
  output logic           a_miso_o,
  output logic           b_miso_o,
  output logic           spi_sclk_o,
  output logic           spi_mosi_o,
  output logic [SSA-1:0] a_ss_n_pin_o,
  output logic [SSB-1:0] b_ss_n_pin_o
);

  assign a_miso_o = spi_miso_i;
  assign b_miso_o = spi_miso_i;

  always_comb begin
    spi_sclk_o   = IDLE_SCLK;
    spi_mosi_o   = 1'b0;
    a_ss_n_pin_o = '1;
    b_ss_n_pin_o = '1;
    if (!switch_i) begin
      if (owner_i == OWNER_ADC) begin
        spi_sclk_o   = a_sclk_i;
        spi_mosi_o   = a_mosi_i;
        a_ss_n_pin_o = a_ss_n_i;
      end else begin
        spi_sclk_o   = b_sclk_i;
        spi_mosi_o   = b_mosi_i;
        b_ss_n_pin_o = b_ss_n_i;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Safe-switching owner arbiter for the shared SPI pins (ADC vs CAN master).
// Ports: sel_req/owner (1=ADC), busy, sticky collision/timeout, flag_clr.
// Optional macro SPI_ARB_TIMEOUT_EN: forced switch after TIMEOUT_CYCLES DRAIN.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   SSA            = 2,
  parameter int   SSB            = 3,
  parameter int   GUARD_CYCLES   = 16,
  parameter int   TIMEOUT_CYCLES = 65535,
  parameter logic IDLE_SCLK      = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel_req,
  input  logic           a_sclk,
  input  logic           a_mosi,
  input  logic [SSA-1:0] a_ss_n,
  output logic           a_miso,
  input  logic           b_sclk,
  input  logic           b_mosi,
  input  logic [SSB-1:0] b_ss_n,
  output logic           b_miso,
  output logic           spi_sclk,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic [SSA-1:0] a_ss_n_pin,
  output logic [SSB-1:0] b_ss_n_pin,
  output logic           owner,
  output logic           busy,
  output logic           collision,
  output logic           timeout,
  input  logic           flag_clr
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GLAST = GW'(GUARD_CYCLES - 1);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          col_q, col_d;
  logic          to_set;

  logic a_act, b_act, own_act, req_diff, nown_low;

  assign a_act    = ~&a_ss_n;
  assign b_act    = ~&b_ss_n;
  assign own_act  = (owner_q == OWNER_ADC) ? a_act : b_act;
  assign req_diff = sel_req != owner_q;

  // During SWITCH neither master owns the bus.
  assign nown_low = (state_q == SWITCH) ? (a_act | b_act)
                  : (owner_q == OWNER_ADC) ? b_act : a_act;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(TIMEOUT_CYCLES - 1);
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          to_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gcnt_d  = '0;
    to_set  = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    dcnt_d  = '0;
`endif
    unique case (state_q)
      OWN: begin
        if (req_diff) state_d = own_act ? DRAIN : GUARD;
      end
      DRAIN: begin
        if (!req_diff) state_d = OWN;
        else if (!own_act) state_d = GUARD;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (dcnt_q == DLAST) begin
          state_d = SWITCH;
          to_set  = 1'b1;
        end else dcnt_d = dcnt_q + 1'b1;
`endif
      end
      GUARD: begin
        if (!req_diff) state_d = OWN;
        else if (own_act) state_d = DRAIN;
        else if (gcnt_q == GLAST) state_d = SWITCH;
        else gcnt_d = gcnt_q + 1'b1;
      end
      SWITCH: begin
        state_d = OWN;
        owner_d = ~owner_q;
      end
      default: state_d = OWN;
    endcase
  end

  // Set has priority over a coincident clear.
  assign col_d = nown_low | (col_q & ~flag_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OWN;
      owner_q <= OWNER_CAN;
      gcnt_q  <= '0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gcnt_q  <= gcnt_d;
      col_q   <= col_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      to_q   <= to_set | (to_q & ~flag_clr);
    end
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign owner     = owner_q;
  assign busy      = state_q != OWN;
  assign collision = col_q;

  spi_arb_port_mux #(
    .SSA       (SSA),
    .SSB       (SSB),
    .IDLE_SCLK (IDLE_SCLK)
  ) u_mux (
    .owner_i      (owner_q),
    .switch_i     (state_q == SWITCH),
    .a_sclk_i     (a_sclk),
    .a_mosi_i     (a_mosi),
    .a_ss_n_i     (a_ss_n),
    .b_sclk_i     (b_sclk),
    .b_mosi_i     (b_mosi),
    .b_ss_n_i     (b_ss_n),
    .spi_miso_i   (spi_miso),
    .a_miso_o     (a_miso),
    .b_miso_o     (b_miso),
    .spi_sclk_o   (spi_sclk),
    .spi_mosi_o   (spi_mosi),
    .a_ss_n_pin_o (a_ss_n_pin),
    .b_ss_n_pin_o (b_ss_n_pin)
  );

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random traffic,
// all compared against a streak-counting reference model.
module tb_spi_bus_arbiter;

  localparam int G = 16;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_req, flag_clr;
  logic       a_sclk, a_mosi, b_sclk, b_mosi, spi_miso;
  logic [1:0] a_ss_n;
  logic [2:0] b_ss_n;
  logic       a_miso, b_miso, spi_sclk, spi_mosi;
  logic [1:0] a_ss_n_pin;
  logic [2:0] b_ss_n_pin;
  logic       owner, busy, collision, timeout;

  int n_chk = 0;
  int n_fail = 0;

  // model: guard/drain streaks count consecutive qualifying edges
  logic m_own, m_sw, m_busy, m_col, m_to;
  int   m_gs, m_ds;

  spi_bus_arbiter #(
    .SSA(2), .SSB(3), .GUARD_CYCLES(G),
    .TIMEOUT_CYCLES(T), .IDLE_SCLK(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req),
    .a_sclk(a_sclk), .a_mosi(a_mosi), .a_ss_n(a_ss_n),
    .a_miso(a_miso),
    .b_sclk(b_sclk), .b_mosi(b_mosi), .b_ss_n(b_ss_n),
    .b_miso(b_miso),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .a_ss_n_pin(a_ss_n_pin), .b_ss_n_pin(b_ss_n_pin),
    .owner(owner), .busy(busy), .collision(collision),
    .timeout(timeout), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_own = 1'b0; m_sw = 1'b0; m_busy = 1'b0;
    m_col = 1'b0; m_to = 1'b0; m_gs = 0; m_ds = 0;
  endtask

  task automatic mstep();
    logic aa, ba, oa, nl, tset;
    aa = (a_ss_n != 2'b11);
    ba = (b_ss_n != 3'b111);
    oa = m_own ? aa : ba;
    nl = m_sw ? (aa | ba) : (m_own ? ba : aa);
    tset = 1'b0;
    m_col = nl | (m_col & ~flag_clr);
    if (m_sw) begin
      m_own = ~m_own; m_sw = 1'b0; m_busy = 1'b0;
      m_gs = 0; m_ds = 0;
    end else if (sel_req == m_own) begin
      m_busy = 1'b0; m_gs = 0; m_ds = 0;
    end else begin
      m_busy = 1'b1;
      if (oa) begin
        m_gs = 0;
        m_ds++;
`ifdef SPI_ARB_TIMEOUT_EN
        if (m_ds == T + 1) begin
          m_sw = 1'b1; tset = 1'b1;
        end
`endif
      end else begin
        m_ds = 0;
        m_gs++;
        if (m_gs == G + 1) m_sw = 1'b1;
      end
    end
    m_to = tset | (m_to & ~flag_clr);
  endtask

  task automatic cmp_all();
    logic       e_sclk, e_mosi;
    logic [1:0] e_a;
    logic [2:0] e_b;
    e_sclk = 1'b0; e_mosi = 1'b0; e_a = 2'b11; e_b = 3'b111;
    if (!m_sw) begin
      if (m_own) begin
        e_sclk = a_sclk; e_mosi = a_mosi; e_a = a_ss_n;
      end else begin
        e_sclk = b_sclk; e_mosi = b_mosi; e_b = b_ss_n;
      end
    end
    chk("owner", owner, m_own);
    chk("busy", busy, m_busy);
    chk("collision", collision, m_col);
    chk("timeout", timeout, m_to);
    chk("sclk", spi_sclk, e_sclk);
    chk("mosi", spi_mosi, e_mosi);
    chk("a_pin", a_ss_n_pin, e_a);
    chk("b_pin", b_ss_n_pin, e_b);
    chk("a_miso", a_miso, spi_miso);
    chk("b_miso", b_miso, spi_miso);
  endtask

  task automatic tick();
    @(posedge clk);
    mstep();
    #1;
    cmp_all();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sel_req = 1'b0; flag_clr = 1'b0;
    a_sclk = 1'b0; a_mosi = 1'b0; a_ss_n = 2'b11;
    b_sclk = 1'b1; b_mosi = 1'b1; b_ss_n = 3'b111;
    spi_miso = 1'b1;
  endtask

  // Runs until owner differs from 'from', bounded; returns edge/busy counts.
  task automatic wait_flip(input logic from, input int bound,
                           output int edges, output int bcnt);
    edges = 0; bcnt = 0;
    while (owner == from && edges < bound) begin
      tick();
      edges++;
      if (busy) bcnt++;
    end
  endtask

  int         e, b;
  int         a_left, b_left;
  logic [1:0] a_pat;
  logic [2:0] b_pat;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int HOLD = 40;
`else
  localparam int HOLD = 100;
`endif

  initial begin
    idle_inputs();
    rst = 1'b1;
    mreset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_ss_n = 3'b101; b_sclk = 1'b1;
    #1;
    chk("rst_owner", owner, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_a_pin", a_ss_n_pin, 2'b11);
    chk("rst_b_pin", b_ss_n_pin, 3'b101);
    chk("rst_sclk", spi_sclk, 1'b1);
    @(negedge clk);
    b_ss_n = 3'b111;
    tick();

    // guard timing: idle owner, request ADC
    sel_req = 1'b1;
    wait_flip(1'b0, 100, e, b);
    chk("guard_edges", e, G + 2);
    chk("guard_busy", b, G + 1);
    // back to CAN
    sel_req = 1'b0;
    wait_flip(1'b1, 100, e, b);
    chk("guard_back", e, G + 2);

    // drain: CAN holds a select, then re-asserts mid-guard
    b_ss_n = 3'b110;
    repeat (5) tick();
    sel_req = 1'b1;
    repeat (HOLD) tick();
    chk("drain_own", owner, 1'b0);
    chk("drain_busy", busy, 1'b1);
    b_ss_n = 3'b111;
    repeat (6) tick();
    b_ss_n = 3'b011;
    repeat (3) tick();
    b_ss_n = 3'b111;
    wait_flip(1'b0, 100, e, b);
    chk("drain_flip", e, G + 2);
    sel_req = 1'b0;
    wait_flip(1'b1, 100, e, b);

    // collision against owner CAN
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    a_ss_n = 2'b10;
    tick();
    chk("col_pin", a_ss_n_pin, 2'b11);
    chk("col_set", collision, 1'b1);
    a_ss_n = 2'b11; flag_clr = 1'b1;
    tick();
    chk("col_clr", collision, 1'b0);
    a_ss_n = 2'b01;
    tick();
    chk("col_win", collision, 1'b1);
    a_ss_n = 2'b11; flag_clr = 1'b0;

    // cancelled switch
    sel_req = 1'b1;
    repeat (4) tick();
    sel_req = 1'b0;
    tick();
    chk("cancel_busy", busy, 1'b0);
    repeat (G + 4) tick();
    chk("cancel_own", owner, 1'b0);

    // CAN select stuck forever
    b_ss_n = 3'b110;
    tick();
    sel_req = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
    wait_flip(1'b0, 200, e, b);
    chk("to_edges", e, T + 2);
    chk("to_flag", timeout, 1'b1);
    chk("to_b_pin", b_ss_n_pin, 3'b111);
    sel_req = 1'b0; b_ss_n = 3'b111;
    wait_flip(1'b1, 100, e, b);
`else
    repeat (200) tick();
    chk("stuck_own", owner, 1'b0);
    chk("stuck_to", timeout, 1'b0);
    sel_req = 1'b0; b_ss_n = 3'b111;
    tick();
`endif

    // random traffic
    a_left = 0; b_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(59) == 0) sel_req = ~sel_req;
      flag_clr = ($urandom_range(19) == 0);
      a_sclk = 1'($urandom); a_mosi = 1'($urandom);
      b_sclk = 1'($urandom); b_mosi = 1'($urandom);
      spi_miso = 1'($urandom);
      if (a_left > 0) begin
        a_ss_n = a_pat; a_left--;
      end else begin
        a_ss_n = 2'b11;
        if ($urandom_range(39) == 0) begin
          a_left = $urandom_range(30, 1);
          a_pat = 2'($urandom_range(2));
        end
      end
      if (b_left > 0) begin
        b_ss_n = b_pat; b_left--;
      end else begin
        b_ss_n = 3'b111;
        if ($urandom_range(39) == 0) begin
          b_left = $urandom_range(30, 1);
          b_pat = 3'($urandom_range(6));
        end
      end
      if (i == 1500) begin
        rst = 1'b1;
        #1;
        mreset();
        chk("arst_owner", owner, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_col", collision, 1'b0);
        chk("arst_a_pin", a_ss_n_pin, 2'b11);
        #2;
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Safe-switching arbiter that shares the single SPI pin set (SCLK, MOSI, MISO on GPIO_0) between the ADC SPI master and the CAN SPI master of the Computer_System. It sits directly downstream of both SPI masters and the spi_select PIO, and directly upstream of the GPIO_0 pins. It replaces the bare combinational select mux. Ownership changes only after the current owner's transaction has finished and a guard interval has passed. Chip selects from the non-owner are blocked and flagged.

## Interface
Parameters:
- SSA, 2, ADC master slave-select width
- SSB, 3, CAN master slave-select width
- GUARD_CYCLES, 16, idle clk cycles required before ownership flips (≥1, counter width $clog2(GUARD_CYCLES+1))
- TIMEOUT_CYCLES, 65535, maximum DRAIN wait before a forced switch (used only with SPI_ARB_TIMEOUT_EN)
- IDLE_SCLK, 0, SCLK level driven during SWITCH

Ports:
- clk  in  1  system clock; all inputs except spi_miso are synchronous to it
- rst  in  1  reset, asynchronous, active-high
- sel_req  in  1  requested owner: 1 = ADC, 0 = CAN (spi_select bit 0)
- a_sclk, a_mosi  in  1  ADC master outputs
- a_ss_n  in  SSA  ADC master slave selects
- a_miso  out  1  MISO to ADC master
- b_sclk, b_mosi  in  1  CAN master outputs
- b_ss_n  in  SSB  CAN master slave selects
- b_miso  out  1  MISO to CAN master
- spi_sclk, spi_mosi  out  1  pin outputs
- spi_miso  in  1  pin input
- a_ss_n_pin  out  SSA  gated ADC selects to pins
- b_ss_n_pin  out  SSB  gated CAN selects to pins
- owner  out  1  current owner, same encoding as sel_req
- busy  out  1  a switch is pending
- collision  out  1  sticky: the non-owner asserted a select
- timeout  out  1  sticky: a forced switch occurred
- flag_clr  in  1  single-cycle clear of collision and timeout

## Operation
- States: OWN, DRAIN, GUARD, SWITCH.
- An owner select is active when its ss_n has any bit low.
- OWN:
  - sel_req ≠ owner and owner select active → DRAIN.
  - sel_req ≠ owner and owner select idle → GUARD; the guard counter loads 0.
- DRAIN:
  - sel_req == owner → OWN (abort).
  - Owner select goes idle → GUARD.
- GUARD:
  - The counter increments every cycle.
  - Owner select becomes active → DRAIN; the counter clears.
  - sel_req == owner → OWN.
  - Counter reaches GUARD_CYCLES-1 → SWITCH.
- SWITCH:
  - Lasts exactly one cycle.
  - All pin selects are driven high, spi_sclk = IDLE_SCLK, spi_mosi = 0.
  - Next edge: owner toggles, → OWN.
- In OWN, DRAIN and GUARD, the pins carry the owner's sclk, mosi and ss_n. The non-owner's ss_n pins are forced all-ones.
- spi_miso is passed combinationally to both a_miso and b_miso.
- busy is high in DRAIN, GUARD and SWITCH; otherwise low.
- collision:
  - Set on any clk edge where the non-owner's ss_n has a low bit.
  - SWITCH counts as both masters being non-owners.
  - Cleared by flag_clr. If set and clear occur together, set wins.
- Reset: state OWN, owner 0 (CAN), busy 0, collision 0, timeout 0, counters 0. Pins carry the CAN master with ADC selects high.
- Reset asserted mid-transfer aborts immediately. The outputs follow the reset values asynchronously.

## Timing
- owner, busy, collision, timeout and state are registered.
- Pin muxing and gating are combinational from the registered owner and state, so there is zero added latency on the SCLK/MOSI/SS paths.
- sel_req toggles at edge k with the owner idle:
  - GUARD is entered at k.
  - SWITCH is entered at k+GUARD_CYCLES.
  - owner flips at k+GUARD_CYCLES+1.
  - busy is high from k through k+GUARD_CYCLES inclusive.
- sel_req toggling twice within GUARD cancels the switch; owner is unchanged.

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - A DRAIN-cycle counter runs in DRAIN.
  - On reaching TIMEOUT_CYCLES, the arbiter goes directly to SWITCH and sets timeout (sticky).
  - The old owner's selects are forced high from the SWITCH cycle onward.
- Not defined: DRAIN waits indefinitely, no DRAIN counter is built, and timeout is tied 0.

## Structure
- Shared package spi_arb_pkg:
  - state enum (OWN, DRAIN, GUARD, SWITCH)
  - owner encoding constants OWNER_ADC = 1'b1, OWNER_CAN = 1'b0
- One sub-module, spi_arb_port_mux: the combinational SCLK/MOSI mux, SS gating and SWITCH forcing.
- The FSM, counters and flags live in the top.

## Test plan
- Reset → owner 0, busy 0, a_ss_n_pin = 2'b11, b_ss_n_pin follows b_ss_n, spi_sclk follows b_sclk.
- Owner idle, sel_req 0→1 at edge k, GUARD_CYCLES = 16 → SWITCH at k+16, owner = 1 at k+17, busy high for exactly 17 cycles, pins idle during SWITCH.
- CAN holds b_ss_n = 3'b110 for 100 cycles, then sel_req → 1 → stays in DRAIN 100 cycles. CAN re-asserts a select at guard count 5 → back to DRAIN. owner flips GUARD_CYCLES+1 cycles after the final release.
- Owner CAN, a_ss_n = 2'b10 asserted → a_ss_n_pin stays 2'b11, collision = 1 next edge. flag_clr with no new collision → 0. flag_clr coincident with a collision → stays 1.
- sel_req pulses 0→1→0 within GUARD → returns to OWN, owner stays 0, busy drops.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 50, CAN select held forever → SWITCH after 50 DRAIN cycles, timeout = 1, owner = 1, b_ss_n_pin = 3'b111. Without the macro: owner never changes, timeout stays 0.
